// File: rtl/cross_bar_pkg.sv
// Shared crossbar definitions: opcode encodings and router state enum.
// Imported by the master request router and its watchdog.
package cross_bar_pkg;

   localparam logic READ_OPP  = 1'b0;
   localparam logic WRITE_OPP = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_RESP = 2'd2
   } router_state_e;

endpackage

// File: rtl/xbar_watchdog.sv
// Cycle watchdog: counts enabled cycles, flags expired at TIMEOUT.
// Ports: aclk, aresetn (sync, active-low), clear, enable, expired.
module xbar_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;

   assign expired = (cnt == CNT_W'(TIMEOUT));

   // Saturates at TIMEOUT so a late response cannot wrap the count.
   always_ff @(posedge aclk) begin
      if (!aresetn)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/master_req_router.sv
// Routes one master request to one of SLAVE_NUM arbiters by top address
// bits, tracks ack/resp, and completes with error on watchdog timeout.
// Ports: aclk, aresetn; master side s_*; arbiter side rd_req, wr_req,
// req_addr, req_wdata, arb_ack, arb_resp, arb_rdata. All outputs registered.
module master_req_router
   import cross_bar_pkg::*;
#(
   parameter int SLAVE_NUM = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int TIMEOUT   = 255
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        s_req,
   input  logic                        s_cmd,
   input  logic [ADDR_W-1:0]           s_addr,
   input  logic [DATA_W-1:0]           s_wdata,
   output logic                        s_ack,
   output logic                        s_resp,
   output logic [DATA_W-1:0]           s_rdata,
   output logic                        s_err,
   output logic [SLAVE_NUM-1:0]        rd_req,
   output logic [SLAVE_NUM-1:0]        wr_req,
   output logic [ADDR_W-1:0]           req_addr,
   output logic [DATA_W-1:0]           req_wdata,
   input  logic [SLAVE_NUM-1:0]        arb_ack,
   input  logic [SLAVE_NUM-1:0]        arb_resp,
   input  logic [SLAVE_NUM*DATA_W-1:0] arb_rdata
);

   localparam int SEL_W = $clog2(SLAVE_NUM);

   router_state_e state, state_nxt;

   logic                 cmd_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [SEL_W-1:0]     sel_q;
   logic [SEL_W-1:0]     sel_in;

   logic                 ack_hit, resp_hit;
   logic                 wd_clr, wd_en, wd_exp;
   logic [DATA_W-1:0]    rdata_sel;

   logic                 s_ack_d, s_resp_d, s_err_d;
   logic [DATA_W-1:0]    s_rdata_d, req_wdata_d;
   logic [SLAVE_NUM-1:0] rd_req_d, wr_req_d;
   logic [ADDR_W-1:0]    req_addr_d;

   assign sel_in    = s_addr[ADDR_W-1 -: SEL_W];
   assign ack_hit   = arb_ack[sel_q];
   assign resp_hit  = arb_resp[sel_q];
   assign rdata_sel = arb_rdata[int'(sel_q)*DATA_W +: DATA_W];

   // Held clear while idle, so the count starts at zero on entering REQ.
   assign wd_clr = (state == ST_IDLE) || ((state == ST_REQ) && ack_hit);
   assign wd_en  = (state != ST_IDLE);

   xbar_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (wd_clr),
      .enable  (wd_en),
      .expired (wd_exp)
   );

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         cmd_q     <= READ_OPP;
         addr_q    <= '0;
         wdata_q   <= '0;
         sel_q     <= '0;
         s_ack     <= 1'b0;
         s_resp    <= 1'b0;
         s_err     <= 1'b0;
         s_rdata   <= '0;
         rd_req    <= '0;
         wr_req    <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         state     <= state_nxt;
         s_ack     <= s_ack_d;
         s_resp    <= s_resp_d;
         s_err     <= s_err_d;
         s_rdata   <= s_rdata_d;
         rd_req    <= rd_req_d;
         wr_req    <= wr_req_d;
         req_addr  <= req_addr_d;
         req_wdata <= req_wdata_d;
         if ((state == ST_IDLE) && s_req) begin
            cmd_q   <= s_cmd;
            addr_q  <= s_addr;
            wdata_q <= (s_cmd == WRITE_OPP) ? s_wdata : '0;
            sel_q   <= sel_in;
         end
      end
   end

   // A real arbiter event wins over a watchdog expiry in the same cycle.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:
            if (s_req) state_nxt = ST_REQ;
         ST_REQ:
            if (ack_hit)
               state_nxt = resp_hit ? ST_IDLE : ST_WAIT_RESP;
            else if (wd_exp)
               state_nxt = ST_IDLE;
         ST_WAIT_RESP:
            if (resp_hit || wd_exp) state_nxt = ST_IDLE;
         default:
            state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ack_d     = 1'b0;
      s_resp_d    = 1'b0;
      s_err_d     = 1'b0;
      s_rdata_d   = '0;
      rd_req_d    = '0;
      wr_req_d    = '0;
      req_addr_d  = '0;
      req_wdata_d = '0;
      unique case (state)
         ST_IDLE:
            if (s_req) begin
               req_addr_d = s_addr;
               if (s_cmd == WRITE_OPP) begin
                  wr_req_d    = SLAVE_NUM'(1) << sel_in;
                  req_wdata_d = s_wdata;
               end else begin
                  rd_req_d = SLAVE_NUM'(1) << sel_in;
               end
            end
         ST_REQ:
            if (ack_hit) begin
               s_ack_d = 1'b1;
               if (resp_hit) begin
                  s_resp_d  = 1'b1;
                  s_rdata_d = (cmd_q == READ_OPP) ? rdata_sel : '0;
               end
            end else if (wd_exp) begin
               s_resp_d  = 1'b1;
               s_err_d   = 1'b1;
               s_rdata_d = '1;
            end else begin
               req_addr_d  = addr_q;
               req_wdata_d = wdata_q;
               if (cmd_q == WRITE_OPP)
                  wr_req_d = SLAVE_NUM'(1) << sel_q;
               else
                  rd_req_d = SLAVE_NUM'(1) << sel_q;
            end
         ST_WAIT_RESP:
            if (resp_hit) begin
               s_resp_d  = 1'b1;
               s_rdata_d = (cmd_q == READ_OPP) ? rdata_sel : '0;
            end else if (wd_exp) begin
               s_resp_d  = 1'b1;
               s_err_d   = 1'b1;
               s_rdata_d = '1;
            end
         default: ;
      endcase
   end

endmodule
